// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller slice: CSR addresses, mstatus
// field positions, exception cause codes, privilege encodings, FSM state type
// and the xtval source selection helper.
package trap_controller_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  // mstatus bit positions
  localparam int unsigned MSTATUS_SIE    = 1;
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_SPIE   = 5;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_SPP    = 8;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Exception cause codes
  localparam logic [4:0] EXCEPT_INST_MISALIGNED  = 5'd0;
  localparam logic [4:0] EXCEPT_ILLEGAL_INST     = 5'd2;
  localparam logic [4:0] EXCEPT_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXCEPT_ECALL_U          = 5'd8;
  localparam logic [4:0] EXCEPT_ECALL_S          = 5'd9;
  localparam logic [4:0] EXCEPT_ECALL_M          = 5'd11;
  localparam logic [4:0] EXCEPT_INST_PAGE_FAULT  = 5'd12;
  localparam logic [4:0] EXCEPT_LOAD_PAGE_FAULT  = 5'd13;
  localparam logic [4:0] EXCEPT_STORE_PAGE_FAULT = 5'd15;
  localparam logic [4:0] EXCEPT_DO_NOTHING       = 5'h1F;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic {StIdle, StRedirect} trap_state_e;

  // Trap value recorded in xtval for a given cause.
  function automatic logic [31:0] tval_select(input logic [4:0]  cause,
                                              input logic [31:0] inst,
                                              input logic [31:0] va_imem,
                                              input logic [31:0] va_dmem);
    case (cause)
      EXCEPT_INST_MISALIGNED, EXCEPT_INST_PAGE_FAULT:  return va_imem;
      EXCEPT_ILLEGAL_INST:                             return inst;
      EXCEPT_LOAD_PAGE_FAULT, EXCEPT_STORE_PAGE_FAULT: return va_dmem;
      default:                                         return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Bus between the trap controller and the rest of the pipeline.
//   CSR port (EX):   csr_addr, csr_we, csr_wdata -> csr_rdata, csr_illegal
//   Redirect (IF):   redirect_valid, redirect_pc -> fetch_stall
// master: pipeline side; slave: trap controller side.
interface trap_controller_if;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output csr_addr, csr_we, csr_wdata, fetch_stall,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_addr, csr_we, csr_wdata, fetch_stall,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_csr_file.sv
// Trap CSR storage: write masks, combinational read mux, csr_illegal, and the
// trap-entry / xret field updates requested by trap_controller.
// Ports: clk, rst (sync, active-high); priv_mode; CSR port (csr_addr, csr_we,
// csr_wdata, csr_rdata, csr_illegal); trap_m/trap_s/do_mret/do_sret strobes
// with trap_cause/trap_epc/trap_tval; medeleg, mtvec, stvec, mepc, sepc,
// mpp, spp values for the controller.
module trap_csr_file
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  priv_mode,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_m,
  input  logic        trap_s,
  input  logic        do_mret,
  input  logic        do_sret,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_tval,
  output logic [31:0] medeleg,
  output logic [31:0] mtvec,
  output logic [31:0] stvec,
  output logic [31:0] mepc,
  output logic [31:0] sepc,
  output logic [1:0]  mpp,
  output logic        spp
);

  logic        mie_q, mpie_q, sie_q, spie_q, spp_q;
  logic [1:0]  mpp_q;
  logic [31:0] medeleg_q, mtvec_q, stvec_q, mepc_q, sepc_q;
  logic [31:0] mcause_q, scause_q, mtval_q, stval_q, mscratch_q, sscratch_q;
  logic [31:0] mstatus_rd, sstatus_rd;
  logic        implemented, wr_en;

  assign mstatus_rd = {19'b0, mpp_q, 2'b0, spp_q, mpie_q, 1'b0, spie_q, 1'b0,
                       mie_q, 1'b0, sie_q, 1'b0};
  assign sstatus_rd = {23'b0, spp_q, 2'b0, spie_q, 3'b0, sie_q, 1'b0};

  always_comb begin
    implemented = 1'b1;
    csr_rdata   = 32'h0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_rd;
      CSR_SSTATUS:  csr_rdata = sstatus_rd;
      CSR_MEDELEG:  csr_rdata = medeleg_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_STVEC:    csr_rdata = stvec_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_SEPC:     csr_rdata = sepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_SCAUSE:   csr_rdata = scause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_STVAL:    csr_rdata = stval_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_SSCRATCH: csr_rdata = sscratch_q;
      default:      implemented = 1'b0;
    endcase
  end

  assign csr_illegal = !implemented || (csr_addr[9:8] > priv_mode);
  // An illegal access becomes a trap downstream; never let it modify state.
  assign wr_en = csr_we && !csr_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      {mie_q, mpie_q, sie_q, spie_q, spp_q} <= '0;
      mpp_q      <= PRIV_U;
      medeleg_q  <= '0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      stvec_q    <= '0;
      mepc_q     <= '0;
      sepc_q     <= '0;
      mcause_q   <= '0;
      scause_q   <= '0;
      mtval_q    <= '0;
      stval_q    <= '0;
      mscratch_q <= '0;
      sscratch_q <= '0;
    end else if (trap_m) begin
      mepc_q   <= trap_epc;
      mcause_q <= {27'b0, trap_cause};
      mtval_q  <= trap_tval;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      mpp_q    <= priv_mode;
    end else if (trap_s) begin
      sepc_q   <= trap_epc;
      scause_q <= {27'b0, trap_cause};
      stval_q  <= trap_tval;
      spie_q   <= sie_q;
      sie_q    <= 1'b0;
      spp_q    <= priv_mode[0];
    end else if (do_mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
      mpp_q  <= PRIV_U;
    end else if (do_sret) begin
      sie_q  <= spie_q;
      spie_q <= 1'b1;
      spp_q  <= 1'b0;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_q  <= csr_wdata[MSTATUS_MIE];
          mpie_q <= csr_wdata[MSTATUS_MPIE];
          sie_q  <= csr_wdata[MSTATUS_SIE];
          spie_q <= csr_wdata[MSTATUS_SPIE];
          spp_q  <= csr_wdata[MSTATUS_SPP];
          // Reserved MPP encoding 10 collapses to U.
          mpp_q  <= (csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10) ? PRIV_U
                    : csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        end
        CSR_SSTATUS: begin
          sie_q  <= csr_wdata[MSTATUS_SIE];
          spie_q <= csr_wdata[MSTATUS_SPIE];
          spp_q  <= csr_wdata[MSTATUS_SPP];
        end
        CSR_MEDELEG:  medeleg_q  <= csr_wdata & ~(32'h1 << EXCEPT_ECALL_M);
        CSR_MTVEC:    mtvec_q    <= {csr_wdata[31:2], 2'b00};
        CSR_STVEC:    stvec_q    <= {csr_wdata[31:2], 2'b00};
        CSR_MEPC:     mepc_q     <= {csr_wdata[31:2], 2'b00};
        CSR_SEPC:     sepc_q     <= {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= csr_wdata;
        CSR_SCAUSE:   scause_q   <= csr_wdata;
        CSR_MTVAL:    mtval_q    <= csr_wdata;
        CSR_STVAL:    stval_q    <= csr_wdata;
        CSR_MSCRATCH: mscratch_q <= csr_wdata;
        CSR_SSCRATCH: sscratch_q <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign medeleg = medeleg_q;
  assign mtvec   = mtvec_q;
  assign stvec   = stvec_q;
  assign mepc    = mepc_q;
  assign sepc    = sepc_q;
  assign mpp     = mpp_q;
  assign spp     = spp_q;

endmodule

// File: rtl/trap_controller.sv
// Trap controller: commits MEM-stage traps (with M/S delegation via medeleg)
// and mret/sret, owns the privilege mode, and drives a registered fetch
// redirect that is held until fetch accepts it.
// Ports: clk, rst (sync, active-high); trapID, trap_pc, faulting_inst,
// faulting_va_imem, faulting_va_dmem, mret_i, sret_i from MEM/hazard;
// bus (slave) carries the CSR port and the redirect handshake; priv_mode out.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      trapID,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] faulting_inst,
  input  logic [XLEN-1:0] faulting_va_imem,
  input  logic [XLEN-1:0] faulting_va_dmem,
  input  logic            mret_i,
  input  logic            sret_i,
  trap_controller_if.slave bus,
  output logic [1:0]      priv_mode
);

  trap_state_e state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]  priv_q, priv_d;

  logic        trap_m, trap_s, do_mret, do_sret, csr_we_gated;
  logic        trap_take, delegate;
  logic [31:0] medeleg, mtvec, stvec, mepc, sepc;
  logic [1:0]  mpp;
  logic        spp;

  assign trap_take = (trapID != EXCEPT_DO_NOTHING);
  assign delegate  = (priv_q != PRIV_M) && medeleg[trapID];

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    priv_d           = priv_q;
    trap_m           = 1'b0;
    trap_s           = 1'b0;
    do_mret          = 1'b0;
    do_sret          = 1'b0;
    csr_we_gated     = bus.csr_we;
    case (state_q)
      StIdle: begin
        // The flushed instruction's CSR write is squashed on trap/xret.
        if (trap_take) begin
          csr_we_gated     = 1'b0;
          state_d          = StRedirect;
          redirect_valid_d = 1'b1;
          if (delegate) begin
            trap_s        = 1'b1;
            priv_d        = PRIV_S;
            redirect_pc_d = stvec;
          end else begin
            trap_m        = 1'b1;
            priv_d        = PRIV_M;
            redirect_pc_d = mtvec;
          end
        end else if (mret_i) begin
          csr_we_gated     = 1'b0;
          do_mret          = 1'b1;
          priv_d           = mpp;
          redirect_pc_d    = mepc;
          state_d          = StRedirect;
          redirect_valid_d = 1'b1;
        end else if (sret_i) begin
          csr_we_gated     = 1'b0;
          do_sret          = 1'b1;
          priv_d           = {1'b0, spp};
          redirect_pc_d    = sepc;
          state_d          = StRedirect;
          redirect_valid_d = 1'b1;
        end
      end
      StRedirect: begin
        if (!bus.fetch_stall) begin
          state_d          = StIdle;
          redirect_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      priv_q           <= PRIV_M;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      priv_q           <= priv_d;
    end
  end

  trap_csr_file #(
    .MTVEC_RESET(MTVEC_RESET)
  ) u_csr_file (
    .clk        (clk),
    .rst        (rst),
    .priv_mode  (priv_q),
    .csr_addr   (bus.csr_addr),
    .csr_we     (csr_we_gated),
    .csr_wdata  (bus.csr_wdata),
    .csr_rdata  (bus.csr_rdata),
    .csr_illegal(bus.csr_illegal),
    .trap_m     (trap_m),
    .trap_s     (trap_s),
    .do_mret    (do_mret),
    .do_sret    (do_sret),
    .trap_cause (trapID),
    .trap_epc   ({trap_pc[31:2], 2'b00}),
    .trap_tval  (tval_select(trapID, faulting_inst, faulting_va_imem, faulting_va_dmem)),
    .medeleg    (medeleg),
    .mtvec      (mtvec),
    .stvec      (stvec),
    .mepc       (mepc),
    .sepc       (sepc),
    .mpp        (mpp),
    .spp        (spp)
  );

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign priv_mode          = priv_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed and randomized checks of trap_controller against a word-level
// reference model of the privileged-architecture rules.
module tb_trap_controller;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0103;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  trap_id;
  logic [31:0] trap_pc, f_inst, va_i, va_d;
  logic        mret, sret;
  logic [1:0]  priv;

  int n_checks = 0;
  int n_fail   = 0;

  trap_controller_if bus ();

  trap_controller #(
    .MTVEC_RESET(MTVEC_RST),
    .XLEN       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trapID          (trap_id),
    .trap_pc         (trap_pc),
    .faulting_inst   (f_inst),
    .faulting_va_imem(va_i),
    .faulting_va_dmem(va_d),
    .mret_i          (mret),
    .sret_i          (sret),
    .bus             (bus),
    .priv_mode       (priv)
  );

  always #50 clk = ~clk;

  // Reference model: architectural CSR words.
  logic [1:0]  m_priv;
  logic [31:0] m_ms, m_medeleg, m_mtvec, m_stvec, m_mepc, m_sepc;
  logic [31:0] m_mcause, m_scause, m_mtval, m_stval, m_mscratch, m_sscratch;
  logic        m_busy, m_rv;
  logic [31:0] m_rpc;

  logic [11:0] addrs [15] = '{12'h300, 12'h100, 12'h302, 12'h305, 12'h105, 12'h341, 12'h141,
                              12'h342, 12'h142, 12'h343, 12'h143, 12'h340, 12'h140,
                              12'h7C0, 12'h180};
  logic [4:0]  causes [10] = '{5'd0, 5'd2, 5'd3, 5'd5, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd15};

  function automatic bit m_impl(input logic [11:0] a);
    for (int i = 0; i < 13; i++) if (addrs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_ms;
      12'h100: return m_ms & 32'h0000_0122;
      12'h302: return m_medeleg;
      12'h305: return m_mtvec;
      12'h105: return m_stvec;
      12'h341: return m_mepc;
      12'h141: return m_sepc;
      12'h342: return m_mcause;
      12'h142: return m_scause;
      12'h343: return m_mtval;
      12'h143: return m_stval;
      12'h340: return m_mscratch;
      12'h140: return m_sscratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin
        m_ms = d & 32'h0000_19AA;
        if (m_ms[12:11] == 2'b10) m_ms[12:11] = 2'b00;
      end
      12'h100: m_ms = (m_ms & ~32'h0000_0122) | (d & 32'h0000_0122);
      12'h302: m_medeleg = d & ~32'h0000_0800;
      12'h305: m_mtvec = d & ~32'h3;
      12'h105: m_stvec = d & ~32'h3;
      12'h341: m_mepc = d & ~32'h3;
      12'h141: m_sepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h142: m_scause = d;
      12'h343: m_mtval = d;
      12'h143: m_stval = d;
      12'h340: m_mscratch = d;
      12'h140: m_sscratch = d;
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit          consumed;
    logic [31:0] tv;
    if (rst) begin
      m_priv = 2'b11; m_ms = 0; m_medeleg = 0; m_mtvec = 32'h0000_0100; m_stvec = 0;
      m_mepc = 0; m_sepc = 0; m_mcause = 0; m_scause = 0; m_mtval = 0; m_stval = 0;
      m_mscratch = 0; m_sscratch = 0; m_busy = 0; m_rv = 0; m_rpc = 0;
      return;
    end
    consumed = 0;
    if (!m_busy) begin
      if (trap_id != 5'h1F) begin
        if (trap_id == 0 || trap_id == 12) tv = va_i;
        else if (trap_id == 2) tv = f_inst;
        else if (trap_id == 13 || trap_id == 15) tv = va_d;
        else tv = 0;
        if (m_priv != 2'b11 && m_medeleg[trap_id]) begin
          m_sepc = trap_pc & ~32'h3; m_scause = 32'(trap_id); m_stval = tv;
          m_ms[5] = m_ms[1]; m_ms[1] = 0; m_ms[8] = m_priv[0];
          m_priv = 2'b01; m_rpc = m_stvec;
        end else begin
          m_mepc = trap_pc & ~32'h3; m_mcause = 32'(trap_id); m_mtval = tv;
          m_ms[7] = m_ms[3]; m_ms[3] = 0; m_ms[12:11] = m_priv;
          m_priv = 2'b11; m_rpc = m_mtvec;
        end
        consumed = 1;
      end else if (mret) begin
        m_priv = m_ms[12:11]; m_ms[3] = m_ms[7]; m_ms[7] = 1; m_ms[12:11] = 0;
        m_rpc = m_mepc; consumed = 1;
      end else if (sret) begin
        m_priv = {1'b0, m_ms[8]}; m_ms[1] = m_ms[5]; m_ms[5] = 1; m_ms[8] = 0;
        m_rpc = m_sepc; consumed = 1;
      end
      if (consumed) begin m_busy = 1; m_rv = 1; end
    end else if (!bus.fetch_stall) begin
      m_busy = 0; m_rv = 0;
    end
    if (!consumed && bus.csr_we && m_impl(bus.csr_addr) && bus.csr_addr[9:8] <= m_priv)
      m_write(bus.csr_addr, bus.csr_wdata);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_addr = a;
    #1;
    d = bus.csr_rdata;
  endtask

  task automatic chk_csr(input logic [11:0] a);
    bus.csr_addr = a;
    #1;
    chk($sformatf("rdata %03h", a), bus.csr_rdata, m_read(a));
    chk($sformatf("illegal %03h", a), 32'(bus.csr_illegal),
        32'(!m_impl(a) || (a[9:8] > m_priv)));
  endtask

  task automatic chk_out();
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("priv_mode", 32'(priv), 32'(m_priv));
  endtask

  task automatic chk_all();
    chk_out();
    for (int i = 0; i < 15; i++) chk_csr(addrs[i]);
  endtask

  task automatic idle_inputs();
    trap_id = 5'h1F; mret = 0; sret = 0;
    bus.csr_we = 0; bus.fetch_stall = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr = a; bus.csr_wdata = d; bus.csr_we = 1;
    tick();
    bus.csr_we = 0;
  endtask

  // From M: mret to U-mode at address tgt, then let fetch take the redirect.
  task automatic go_user(input logic [31:0] tgt);
    wr(12'h300, 32'h0);
    wr(12'h341, tgt);
    mret = 1;
    tick();
    mret = 0;
    tick();
  endtask

  logic [31:0] d;

  initial begin
    rst = 1; idle_inputs();
    trap_pc = 0; f_inst = 0; va_i = 0; va_d = 0;
    bus.csr_addr = 0; bus.csr_wdata = 0;
    tick(); tick();
    rst = 0;
    chk("reset redirect_valid", 32'(bus.redirect_valid), 32'h0);
    chk("reset redirect_pc", bus.redirect_pc, 32'h0);
    chk("reset priv", 32'(priv), 32'h3);
    rd(12'h305, d); chk("reset mtvec", d, 32'h0000_0100);
    chk_all();

    // Illegal instruction from U, not delegated
    wr(12'h305, 32'h200);
    go_user(32'h0);
    chk("u-mode entered", 32'(priv), 32'h0);
    trap_id = 5'd2; trap_pc = 32'h104; f_inst = 32'hFFFF_FFFF;
    tick();
    trap_id = 5'h1F;
    chk("t1 valid", 32'(bus.redirect_valid), 32'h1);
    chk("t1 pc", bus.redirect_pc, 32'h200);
    chk("t1 priv", 32'(priv), 32'h3);
    rd(12'h341, d); chk("t1 mepc", d, 32'h104);
    rd(12'h342, d); chk("t1 mcause", d, 32'h2);
    rd(12'h343, d); chk("t1 mtval", d, 32'hFFFF_FFFF);
    rd(12'h300, d); chk("t1 mpp", d & 32'h1800, 32'h0);
    tick();
    chk("t1 handoff", 32'(bus.redirect_valid), 32'h0);

    // Load page fault from U, delegated to S
    wr(12'h302, 32'h2000);
    wr(12'h105, 32'h300);
    go_user(32'h0);
    trap_id = 5'd13; trap_pc = 32'h50; va_d = 32'h8000_1234;
    tick();
    trap_id = 5'h1F;
    chk("t2 pc", bus.redirect_pc, 32'h300);
    chk("t2 priv", 32'(priv), 32'h1);
    rd(12'h142, d); chk("t2 scause", d, 32'd13);
    rd(12'h143, d); chk("t2 stval", d, 32'h8000_1234);
    rd(12'h141, d); chk("t2 sepc", d, 32'h50);
    rd(12'h100, d); chk("t2 spp", d & 32'h100, 32'h0);
    rd(12'h342, d); chk("t2 mcause kept", d, 32'h2);
    rd(12'h343, d); chk("t2 mtval kept", d, 32'hFFFF_FFFF);
    tick();

    // ecall from S (not delegated) to reach M, then mret to S
    trap_id = 5'd9; tick(); trap_id = 5'h1F; tick();
    chk("t3 in M", 32'(priv), 32'h3);
    wr(12'h300, 32'h0000_0880);
    wr(12'h341, 32'h400);
    mret = 1; tick(); mret = 0;
    chk("t3 priv", 32'(priv), 32'h1);
    chk("t3 pc", bus.redirect_pc, 32'h400);
    rd(12'h300, d); chk("t3 mstatus", d, 32'h0000_0088);
    tick();

    // Trap with fetch stalled three cycles; second trap ignored
    trap_id = 5'd2; trap_pc = 32'h208; tick();
    trap_id = 5'h1F; bus.fetch_stall = 1;
    chk("t4 c1 valid", 32'(bus.redirect_valid), 32'h1);
    chk("t4 c1 pc", bus.redirect_pc, 32'h200);
    trap_id = 5'd12; trap_pc = 32'h998; tick(); trap_id = 5'h1F;
    chk("t4 c2 valid", 32'(bus.redirect_valid), 32'h1);
    chk("t4 c2 pc", bus.redirect_pc, 32'h200);
    tick();
    chk("t4 c3 valid", 32'(bus.redirect_valid), 32'h1);
    tick();
    chk("t4 c4 valid", 32'(bus.redirect_valid), 32'h1);
    chk("t4 c4 pc", bus.redirect_pc, 32'h200);
    bus.fetch_stall = 0;
    tick();
    chk("t4 released", 32'(bus.redirect_valid), 32'h0);
    rd(12'h341, d); chk("t4 mepc", d, 32'h208);
    rd(12'h342, d); chk("t4 mcause", d, 32'h2);

    // Trap and CSR write in the same cycle
    trap_id = 5'd12; trap_pc = 32'h300; va_i = 32'h1234_5678;
    bus.csr_addr = 12'h340; bus.csr_wdata = 32'hDEAD; bus.csr_we = 1;
    tick();
    trap_id = 5'h1F; bus.csr_we = 0;
    rd(12'h340, d); chk("t5 mscratch dropped", d, 32'h0);
    rd(12'h342, d); chk("t5 mcause", d, 32'd12);
    rd(12'h343, d); chk("t5 mtval", d, 32'h1234_5678);
    tick();
    wr(12'h340, 32'hDEAD);
    rd(12'h340, d); chk("t5 mscratch", d, 32'hDEAD);

    // Reset while holding a redirect
    trap_id = 5'd3; bus.fetch_stall = 1; tick(); trap_id = 5'h1F;
    chk("t6 in redirect", 32'(bus.redirect_valid), 32'h1);
    rst = 1; tick(); rst = 0; bus.fetch_stall = 0;
    chk("t6 valid", 32'(bus.redirect_valid), 32'h0);
    chk("t6 priv", 32'(priv), 32'h3);
    rd(12'h305, d); chk("t6 mtvec", d, 32'h0000_0100);
    rd(12'h341, d); chk("t6 mepc", d, 32'h0);
    chk_all();

    // Randomized traffic against the model
    for (int it = 0; it < 500; it++) begin
      rst = ($urandom_range(0, 120) == 0);
      trap_id = ($urandom_range(0, 3) == 0) ? causes[$urandom_range(0, 9)] : 5'h1F;
      mret = (m_priv == 2'b11) && ($urandom_range(0, 7) == 0);
      sret = !mret && (m_priv != 2'b00) && ($urandom_range(0, 7) == 0);
      bus.fetch_stall = ($urandom_range(0, 2) == 0);
      bus.csr_we = ($urandom_range(0, 2) == 0);
      bus.csr_addr = addrs[$urandom_range(0, 14)];
      bus.csr_wdata = $urandom();
      trap_pc = $urandom(); f_inst = $urandom(); va_i = $urandom(); va_d = $urandom();
      tick();
      idle_inputs();
      rst = 0;
      chk_out();
      chk_csr(addrs[$urandom_range(0, 14)]);
      if (it % 50 == 49) chk_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
